// File: rtl/fm_axi_pkg.sv
// Shared types and constant AXI field values for the fm command masters.
package fm_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_RSP
    } state_t;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [2:0] SIZE_32B    = 3'b010;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/fm_axi_timeout_cnt.sv
// Response watchdog: held at zero while cleared, counts while running,
// flags expiry on the cycle the count sits at TIMEOUT_CYCLES-1.
module fm_axi_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    assign expire = run && (count_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (run && !expire) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fm_axi_cmd_master.sv
// Single-outstanding AXI4 master: turns read/write commands into single-beat
// AR/R or AW/W/B transactions, each tagged with a fresh ID and guarded by a timeout.
module fm_axi_cmd_master
    import fm_axi_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH   = 32,
    parameter int unsigned AXI_ID_BIT_COUNT = 6,
    parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
    input  logic                        clk_axi,
    input  logic                        reset_axi_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]       cmd_wdata,
    input  logic [STRB_WIDTH-1:0]       cmd_wstrb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        rsp_timeout,
    output logic [AXI_ADDR_WIDTH-1:0]   master_readMOSI_araddr,
    output logic [AXI_ID_BIT_COUNT-1:0] master_readMOSI_arid,
    output logic                        master_readMOSI_arvalid,
    output logic [7:0]                  master_readMOSI_arlen,
    output logic [2:0]                  master_readMOSI_arsize,
    output logic [1:0]                  master_readMOSI_arburst,
    output logic [2:0]                  master_readMOSI_arprot,
    output logic                        master_readMOSI_arlock,
    output logic [3:0]                  master_readMOSI_arcache,
    output logic [3:0]                  master_readMOSI_arqos,
    output logic [3:0]                  master_readMOSI_arregion,
    output logic                        master_readMOSI_aruser,
    output logic                        master_readMOSI_rready,
    input  logic                        master_readMISO_arready,
    input  logic [AXI_ID_BIT_COUNT-1:0] master_readMISO_rid,
    input  logic [DATA_WIDTH-1:0]       master_readMISO_rdata,
    input  logic                        master_readMISO_rvalid,
    input  logic [1:0]                  master_readMISO_rresp,
    input  logic                        master_readMISO_rlast,
    input  logic                        master_readMISO_ruser,
    output logic [AXI_ADDR_WIDTH-1:0]   master_writeMOSI_awaddr,
    output logic [AXI_ID_BIT_COUNT-1:0] master_writeMOSI_awid,
    output logic                        master_writeMOSI_awvalid,
    output logic [7:0]                  master_writeMOSI_awlen,
    output logic [2:0]                  master_writeMOSI_awsize,
    output logic [1:0]                  master_writeMOSI_awburst,
    output logic [2:0]                  master_writeMOSI_awprot,
    output logic                        master_writeMOSI_awlock,
    output logic [3:0]                  master_writeMOSI_awcache,
    output logic [3:0]                  master_writeMOSI_awqos,
    output logic [3:0]                  master_writeMOSI_awregion,
    output logic                        master_writeMOSI_awuser,
    output logic [AXI_ID_BIT_COUNT-1:0] master_writeMOSI_wid,
    output logic [DATA_WIDTH-1:0]       master_writeMOSI_wdata,
    output logic                        master_writeMOSI_wvalid,
    output logic [STRB_WIDTH-1:0]       master_writeMOSI_wstrb,
    output logic                        master_writeMOSI_wlast,
    output logic                        master_writeMOSI_wuser,
    output logic                        master_writeMOSI_bready,
    input  logic                        master_writeMISO_awready,
    input  logic                        master_writeMISO_wready,
    input  logic [AXI_ID_BIT_COUNT-1:0] master_writeMISO_bid,
    input  logic                        master_writeMISO_bvalid,
    input  logic [1:0]                  master_writeMISO_bresp,
    input  logic                        master_writeMISO_buser
);

    state_t                      state_reg;
    logic [AXI_ID_BIT_COUNT-1:0] txn_id_reg;
    logic [AXI_ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]       wdata_reg;
    logic [STRB_WIDTH-1:0]       wstrb_reg;
    logic                        cmd_ready_reg;
    logic                        awvalid_reg;
    logic                        wvalid_reg;
    logic                        arvalid_reg;
    logic                        bready_reg;
    logic                        rready_reg;
    logic                        rsp_valid_reg;
    logic [DATA_WIDTH-1:0]       rsp_rdata_reg;
    logic [1:0]                  rsp_resp_reg;
    logic                        rsp_timeout_reg;
    logic                        timer_run;
    logic                        timer_expire;
    logic                        unused_ok;

    assign timer_run = (state_reg == ST_WR_RESP) || (state_reg == ST_RD_RESP);
    assign unused_ok = &{1'b0, master_readMISO_rlast, master_readMISO_ruser, master_writeMISO_buser};

    fm_axi_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk_axi),
        .rst_n  (reset_axi_n),
        .clear  (!timer_run),
        .run    (timer_run),
        .expire (timer_expire)
    );

    always_ff @(posedge clk_axi or negedge reset_axi_n) begin
        if (!reset_axi_n) begin
            state_reg       <= ST_IDLE;
            txn_id_reg      <= '0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            wstrb_reg       <= '0;
            cmd_ready_reg   <= 1'b0;
            awvalid_reg     <= 1'b0;
            wvalid_reg      <= 1'b0;
            arvalid_reg     <= 1'b0;
            bready_reg      <= 1'b0;
            rready_reg      <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= '0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Both response channels stay open here so stale beats drain.
                    cmd_ready_reg <= 1'b1;
                    bready_reg    <= 1'b1;
                    rready_reg    <= 1'b1;
                    if (cmd_valid && cmd_ready_reg) begin
                        cmd_ready_reg <= 1'b0;
                        bready_reg    <= 1'b0;
                        rready_reg    <= 1'b0;
                        addr_reg      <= cmd_addr;
                        wdata_reg     <= cmd_wdata;
                        wstrb_reg     <= cmd_wstrb;
                        txn_id_reg    <= txn_id_reg + AXI_ID_BIT_COUNT'(1);
                        if (cmd_write) begin
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            state_reg   <= ST_WR_REQ;
                        end else begin
                            arvalid_reg <= 1'b1;
                            state_reg   <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (master_writeMISO_awready) awvalid_reg <= 1'b0;
                    if (master_writeMISO_wready)  wvalid_reg  <= 1'b0;
                    if ((!awvalid_reg || master_writeMISO_awready) &&
                        (!wvalid_reg  || master_writeMISO_wready)) begin
                        bready_reg <= 1'b1;
                        state_reg  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (master_writeMISO_bvalid && (master_writeMISO_bid == txn_id_reg)) begin
                        rsp_valid_reg   <= 1'b1;
                        rsp_rdata_reg   <= '0;
                        rsp_resp_reg    <= master_writeMISO_bresp;
                        rsp_timeout_reg <= 1'b0;
                        bready_reg      <= 1'b0;
                        state_reg       <= ST_RSP;
                    end else if (timer_expire) begin
                        rsp_valid_reg   <= 1'b1;
                        rsp_rdata_reg   <= '0;
                        rsp_resp_reg    <= RESP_SLVERR;
                        rsp_timeout_reg <= 1'b1;
                        bready_reg      <= 1'b0;
                        state_reg       <= ST_RSP;
                    end
                end
                ST_RD_REQ: begin
                    if (master_readMISO_arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (master_readMISO_rvalid && (master_readMISO_rid == txn_id_reg)) begin
                        rsp_valid_reg   <= 1'b1;
                        rsp_rdata_reg   <= master_readMISO_rdata;
                        rsp_resp_reg    <= master_readMISO_rresp;
                        rsp_timeout_reg <= 1'b0;
                        rready_reg      <= 1'b0;
                        state_reg       <= ST_RSP;
                    end else if (timer_expire) begin
                        rsp_valid_reg   <= 1'b1;
                        rsp_rdata_reg   <= '0;
                        rsp_resp_reg    <= RESP_SLVERR;
                        rsp_timeout_reg <= 1'b1;
                        rready_reg      <= 1'b0;
                        state_reg       <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        bready_reg    <= 1'b1;
                        rready_reg    <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_resp    = rsp_resp_reg;
    assign rsp_timeout = rsp_timeout_reg;

    assign master_readMOSI_araddr   = addr_reg;
    assign master_readMOSI_arid     = txn_id_reg;
    assign master_readMOSI_arvalid  = arvalid_reg;
    assign master_readMOSI_arlen    = 8'd0;
    assign master_readMOSI_arsize   = SIZE_32B;
    assign master_readMOSI_arburst  = BURST_INCR;
    assign master_readMOSI_arprot   = 3'd0;
    assign master_readMOSI_arlock   = 1'b0;
    assign master_readMOSI_arcache  = 4'd0;
    assign master_readMOSI_arqos    = 4'd0;
    assign master_readMOSI_arregion = 4'd0;
    assign master_readMOSI_aruser   = 1'b0;
    assign master_readMOSI_rready   = rready_reg;

    assign master_writeMOSI_awaddr   = addr_reg;
    assign master_writeMOSI_awid     = txn_id_reg;
    assign master_writeMOSI_awvalid  = awvalid_reg;
    assign master_writeMOSI_awlen    = 8'd0;
    assign master_writeMOSI_awsize   = SIZE_32B;
    assign master_writeMOSI_awburst  = BURST_INCR;
    assign master_writeMOSI_awprot   = 3'd0;
    assign master_writeMOSI_awlock   = 1'b0;
    assign master_writeMOSI_awcache  = 4'd0;
    assign master_writeMOSI_awqos    = 4'd0;
    assign master_writeMOSI_awregion = 4'd0;
    assign master_writeMOSI_awuser   = 1'b0;
    assign master_writeMOSI_wid      = txn_id_reg;
    assign master_writeMOSI_wdata    = wdata_reg;
    assign master_writeMOSI_wvalid   = wvalid_reg;
    assign master_writeMOSI_wstrb    = wstrb_reg;
    assign master_writeMOSI_wlast    = 1'b1;
    assign master_writeMOSI_wuser    = 1'b0;
    assign master_writeMOSI_bready   = bready_reg;

endmodule

// File: tb/tb_fm_axi_cmd_master.sv
// Directed and randomized bench for fm_axi_cmd_master: the bench plays the AXI
// slave cycle by cycle and predicts every response from a word-level memory model.
module tb_fm_axi_cmd_master;

    localparam int AW  = 32;
    localparam int IDW = 6;
    localparam int TO  = 16;

    logic clk_axi = 1'b0;
    always #5 clk_axi = ~clk_axi;

    logic           reset_axi_n = 1'b0;
    logic           cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
    logic [AW-1:0]  cmd_addr = '0;
    logic [31:0]    cmd_wdata = '0;
    logic [3:0]     cmd_wstrb = '0;
    logic           cmd_ready, rsp_valid, rsp_timeout;
    logic [31:0]    rsp_rdata;
    logic [1:0]     rsp_resp;
    logic [AW-1:0]  araddr, awaddr;
    logic [IDW-1:0] arid, awid, wid;
    logic           arvalid, awvalid, wvalid, rready, bready, arlock, awlock, aruser, awuser, wlast, wuser;
    logic [7:0]     arlen, awlen;
    logic [2:0]     arsize, awsize, arprot, awprot;
    logic [1:0]     arburst, awburst;
    logic [3:0]     arcache, awcache, arqos, awqos, arregion, awregion, wstrb;
    logic [31:0]    wdata;
    logic           arready = 1'b0, rvalid = 1'b0, rlast = 1'b1, ruser = 1'b0;
    logic [IDW-1:0] rid = '0, bid = '0;
    logic [31:0]    rdata = '0;
    logic [1:0]     rresp = '0, bresp = '0;
    logic           awready = 1'b0, wready = 1'b0, bvalid = 1'b0, buser = 1'b0;

    int             n_assert = 0;
    int             n_fail = 0;
    logic [IDW-1:0] exp_id = '0;
    logic [31:0]    ref_mem [16];
    logic [31:0]    slv_mem [16];

    fm_axi_cmd_master #(
        .AXI_ADDR_WIDTH(AW), .AXI_ID_BIT_COUNT(IDW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_axi(clk_axi), .reset_axi_n(reset_axi_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .master_readMOSI_araddr(araddr), .master_readMOSI_arid(arid),
        .master_readMOSI_arvalid(arvalid), .master_readMOSI_arlen(arlen),
        .master_readMOSI_arsize(arsize), .master_readMOSI_arburst(arburst),
        .master_readMOSI_arprot(arprot), .master_readMOSI_arlock(arlock),
        .master_readMOSI_arcache(arcache), .master_readMOSI_arqos(arqos),
        .master_readMOSI_arregion(arregion), .master_readMOSI_aruser(aruser),
        .master_readMOSI_rready(rready),
        .master_readMISO_arready(arready), .master_readMISO_rid(rid),
        .master_readMISO_rdata(rdata), .master_readMISO_rvalid(rvalid),
        .master_readMISO_rresp(rresp), .master_readMISO_rlast(rlast),
        .master_readMISO_ruser(ruser),
        .master_writeMOSI_awaddr(awaddr), .master_writeMOSI_awid(awid),
        .master_writeMOSI_awvalid(awvalid), .master_writeMOSI_awlen(awlen),
        .master_writeMOSI_awsize(awsize), .master_writeMOSI_awburst(awburst),
        .master_writeMOSI_awprot(awprot), .master_writeMOSI_awlock(awlock),
        .master_writeMOSI_awcache(awcache), .master_writeMOSI_awqos(awqos),
        .master_writeMOSI_awregion(awregion), .master_writeMOSI_awuser(awuser),
        .master_writeMOSI_wid(wid), .master_writeMOSI_wdata(wdata),
        .master_writeMOSI_wvalid(wvalid), .master_writeMOSI_wstrb(wstrb),
        .master_writeMOSI_wlast(wlast), .master_writeMOSI_wuser(wuser),
        .master_writeMOSI_bready(bready),
        .master_writeMISO_awready(awready), .master_writeMISO_wready(wready),
        .master_writeMISO_bid(bid), .master_writeMISO_bvalid(bvalid),
        .master_writeMISO_bresp(bresp), .master_writeMISO_buser(buser)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_arvalid"}, arvalid, 1'b0);
        check({tag, "_awvalid"}, awvalid, 1'b0);
        check({tag, "_wvalid"}, wvalid, 1'b0);
        check({tag, "_rready"}, rready, 1'b0);
        check({tag, "_bready"}, bready, 1'b0);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rsp_fields"}, {rsp_timeout, rsp_resp, rsp_rdata}, 35'd0);
        check({tag, "_arid"}, arid, 6'd0);
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic send_cmd(input bit wr, input logic [31:0] addr, data, input logic [3:0] strb);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk_axi);
            n++;
        end
        check("cmd_accept_bound", n < 50, 1'b1);
        @(negedge clk_axi);
        cmd_valid = 1'b0;
        exp_id = exp_id + 6'd1;
    endtask

    task automatic wr_req_phase(input int da, input int dw, input logic [31:0] addr, data, input logic [3:0] strb);
        logic [31:0] cap_addr = '0, cap_data = '0;
        logic [3:0]  cap_strb = '0;
        int last = (da > dw) ? da : dw;
        for (int k = 0; k <= last; k++) begin
            check("awvalid", awvalid, k <= da);
            check("wvalid", wvalid, k <= dw);
            if (k == da) begin
                check("awaddr", awaddr, addr);
                check("awid", awid, exp_id);
                cap_addr = awaddr;
            end
            if (k == dw) begin
                check("wid", wid, exp_id);
                check("wdata", wdata, data);
                check("wstrb", wstrb, strb);
                cap_data = wdata;
                cap_strb = wstrb;
            end
            awready = (k == da);
            wready  = (k == dw);
            @(negedge clk_axi);
        end
        awready = 1'b0; wready = 1'b0;
        check("aw_w_done", {awvalid, wvalid}, 2'b00);
        check("bready_wr_resp", bready, 1'b1);
        for (int b = 0; b < 4; b++)
            if (cap_strb[b]) slv_mem[cap_addr[5:2]][8*b +: 8] = cap_data[8*b +: 8];
    endtask

    task automatic rd_req_phase(input int da, input logic [31:0] addr);
        for (int k = 0; k <= da; k++) begin
            check("arvalid", arvalid, 1'b1);
            check("ar_rready_low", rready, 1'b0);
            if (k == da) begin
                check("araddr", araddr, addr);
                check("arid", arid, exp_id);
            end
            arready = (k == da);
            @(negedge clk_axi);
        end
        arready = 1'b0;
        check("arvalid_done", arvalid, 1'b0);
        check("rready_rd_resp", rready, 1'b1);
    endtask

    // Slave answers d cycles into the response phase, or never; rsp_valid is due one
    // cycle after the matching beat, or TO cycles after the address handshake.
    task automatic resp_phase(input bit wr, input bit respond, input int d, input logic [1:0] code,
                              input logic [31:0] sdata, input bit stale, input logic [31:0] exp_rdata);
        int  fire = respond ? d + 1 : TO;
        bit  beat, sbeat;
        for (int m = 0; m <= fire; m++) begin
            if (m < fire) begin
                check("rsp_valid_early", rsp_valid, 1'b0);
                check(wr ? "bready_open" : "rready_open", wr ? bready : rready, 1'b1);
            end else begin
                check("rsp_valid", rsp_valid, 1'b1);
                check("rsp_timeout", rsp_timeout, !respond);
                check("rsp_resp", rsp_resp, respond ? code : 2'b10);
                check("rsp_rdata", rsp_rdata, exp_rdata);
            end
            beat  = respond && (m == d);
            sbeat = stale && (m == 0) && !beat;
            if (wr) begin
                bvalid = beat || sbeat;
                bid    = beat ? exp_id : (exp_id ^ 6'h01);
                bresp  = beat ? code : ~code;
            end else begin
                rvalid = beat || sbeat;
                rid    = beat ? exp_id : (exp_id ^ 6'h01);
                rresp  = beat ? code : ~code;
                rdata  = beat ? sdata : ~sdata;
            end
            if (m < fire) @(negedge clk_axi);
        end
        bvalid = 1'b0; rvalid = 1'b0;
    endtask

    task automatic rsp_phase(input int hold, input bit to, input logic [1:0] resp, input logic [31:0] rd);
        for (int h = 0; h < hold; h++) begin
            check("hold_cmd_ready", cmd_ready, 1'b0);
            check("hold_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, to, resp, rd});
            @(negedge clk_axi);
        end
        rsp_ready = 1'b1;
        @(negedge clk_axi);
        rsp_ready = 1'b0;
        check("rsp_done", rsp_valid, 1'b0);
        check("idle_cmd_ready", cmd_ready, 1'b1);
    endtask

    task automatic run_txn(input bit wr, input logic [31:0] addr, data, input logic [3:0] strb,
                           input int da, input int dw, input bit respond, input int d,
                           input logic [1:0] code, input bit stale, input int hold);
        logic [3:0]  idx = addr[5:2];
        logic [31:0] exp_rdata;
        send_cmd(wr, addr, data, strb);
        if (wr) begin
            wr_req_phase(da, dw, addr, data, strb);
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
            exp_rdata = '0;
        end else begin
            rd_req_phase(da, addr);
            exp_rdata = respond ? ref_mem[idx] : 32'd0;
        end
        resp_phase(wr, respond, d, code, slv_mem[idx], stale, exp_rdata);
        rsp_phase(hold, !respond, respond ? code : 2'b10, exp_rdata);
        $display("txn wr=%0b addr=0x%08h id=%0d respond=%0b d=%0d stale=%0b hold=%0d exp_rdata=0x%08h",
                 wr, addr, exp_id, respond, d, stale, hold, exp_rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end
        ref_mem[1] = 32'h1234_5678;
        slv_mem[1] = 32'h1234_5678;

        // Reset state and constant address/data fields.
        @(negedge clk_axi);
        check_idle_outputs("reset");
        check("ar_consts", {arlen, arsize, arburst, arprot, arlock, arcache, arqos, arregion, aruser},
              {8'd0, 3'b010, 2'b01, 3'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0});
        check("aw_consts", {awlen, awsize, awburst, awprot, awlock, awcache, awqos, awregion, awuser},
              {8'd0, 3'b010, 2'b01, 3'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0});
        check("w_consts", {wlast, wuser}, 2'b10);
        @(negedge clk_axi);
        reset_axi_n = 1'b1;
        @(negedge clk_axi);
        check("post_reset_cmd_ready", cmd_ready, 1'b1);
        check("post_reset_drain", {bready, rready}, 2'b11);

        // Directed scenarios.
        run_txn(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b1, 0, 2'b00, 1'b0, 0);
        run_txn(1'b1, 32'h48, 32'hA5C3_0F96, 4'hA, 3, 0, 1'b1, 1, 2'b00, 1'b0, 0);
        run_txn(1'b0, 32'h44, 32'h0, 4'h0, 0, 0, 1'b1, 5, 2'b00, 1'b0, 0);
        run_txn(1'b0, 32'h4C, 32'h0, 4'h0, 0, 0, 1'b0, 0, 2'b00, 1'b0, 0);

        // Late beat for the timed-out read: swallowed in IDLE, no response.
        check("stale_rready", rready, 1'b1);
        rvalid = 1'b1; rid = exp_id; rdata = 32'hCAFE_F00D; rresp = 2'b00;
        @(negedge clk_axi);
        rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stale_no_rsp", {rsp_valid, cmd_ready}, 2'b01);
            @(negedge clk_axi);
        end

        run_txn(1'b0, 32'h40, 32'h0, 4'h0, 1, 0, 1'b1, 2, 2'b01, 1'b1, 10);

        // Reset while waiting for R.
        send_cmd(1'b0, 32'h44, 32'h0, 4'h0);
        rd_req_phase(0, 32'h44);
        repeat (3) @(negedge clk_axi);
        reset_axi_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk_axi);
        reset_axi_n = 1'b1;
        exp_id = '0;
        @(negedge clk_axi);
        check("midreset_recover", cmd_ready, 1'b1);
        run_txn(1'b0, 32'h44, 32'h0, 4'h0, 0, 0, 1'b1, 0, 2'b00, 1'b0, 0);

        // Randomized traffic, long enough to wrap the 6-bit transaction ID.
        for (int t = 0; t < 70; t++) begin
            bit          wr      = 1'($urandom_range(0, 1));
            logic [31:0] addr    = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            logic [31:0] data    = $urandom;
            logic [3:0]  strb    = 4'($urandom_range(0, 15));
            int          da      = $urandom_range(0, 3);
            int          dw      = $urandom_range(0, 3);
            bit          respond = ($urandom_range(0, 7) != 0);
            int          d       = $urandom_range(0, 6);
            logic [1:0]  code    = 2'($urandom_range(0, 3));
            bit          stale   = ((d >= 1) || !respond) && ($urandom_range(0, 1) == 1);
            int          hold    = $urandom_range(0, 3);
            run_txn(wr, addr, data, strb, da, dw, respond, d, code, stale, hold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
